aes_key_sched_ctrl: RTL and testbench
=====================================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Sequencer and store for the AES-128 key schedule. Accepts a 128-bit cipher key over a valid/ready handshake.
//  Iterates rounds 1..10 through one key_round_step instance and stores RK0..RK10 in an 11-entry register file.
//  Serves round keys to the encryption datapath through a registered read port.
//  Sits between the key-load interface and the round datapath's AddRoundKey stages.
// PARAMETERS
//  KSTEP_LAT  2   cycles from driving (step_rnd, step_prev) into key_round_step to its step_key being valid; range 1..4
//  NUM_RND    10  number of derived round keys; fixed at 10 for AES-128, other values unsupported
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    synchronous, active-high reset
//  key_in       in   128  cipher key, word w0 = key_in[127:96]; bytes big-endian
//  key_valid    in   1    key_in is valid
//  key_ready    out  1    block can accept a key; transfer = key_valid & key_ready
//  busy         out  1    expansion in progress
//  sched_valid  out  1    RK0..RK10 hold a complete schedule for the last accepted key
//  done         out  1    one-cycle pulse when the schedule completes
//  rd_en        in   1    read request
//  rd_rnd       in   4    round index 0..10
//  rd_key       out  128  round key, valid one cycle after rd_en
//  rd_valid     out  1    one cycle after rd_en; equals sched_valid as sampled at the rd_en cycle
// BEHAVIOUR
//  Reset (sync): FSM goes to IDLE. Key store and rd_key go to 0; rnd_cnt = 0. key_ready=1; busy, sched_valid, done and rd_valid = 0.
//   Reset mid-expansion aborts the expansion. No done pulse is produced.
//  FSM states: IDLE, WAIT, STORE, DONE.
//   IDLE/DONE: key_ready=1. On transfer: RK0 <= key_in, rnd_cnt <= 1, wait_cnt <= 0, sched_valid <= 0, go to WAIT.
//   WAIT: drive step_rnd=rnd_cnt, step_prev=RK[rnd_cnt-1], held stable for the whole round. wait_cnt increments each cycle.
//    When wait_cnt == KSTEP_LAT-1, go to STORE.
//   STORE: RK[rnd_cnt] <= step_key.
//    If rnd_cnt == 10: go to DONE, sched_valid <= 1, done pulses for the next cycle.
//    Otherwise: rnd_cnt++, wait_cnt <= 0, go to WAIT.
//  busy = 1 in WAIT and STORE. key_ready = 0 in WAIT and STORE (a key_valid there is not accepted).
//  Latency: each round takes KSTEP_LAT+1 cycles. done and sched_valid assert 10*(KSTEP_LAT+1)+1 cycles after the transfer edge.
//   With default KSTEP_LAT this is 31 cycles.
//  A new key accepted in DONE drops sched_valid on the next edge. The old keys remain readable but are flagged rd_valid=0.
//  Rcon by round 1..10: 01,02,04,08,10,20,40,80,1B,36 in the top byte. rnd 0 or >10 gives Rcon=0 (unused).
//  Per step: temp = SubWord(RotWord(prev.w3)) ^ Rcon; w0' = prev.w0^temp; w1' = prev.w1^w0'; w2' = prev.w2^w1'; w3' = prev.w3^w2'.
//  Read port: rd_key <= (rd_rnd <= 10) ? RK[rd_rnd] : 0, registered. Without rd_en, rd_key holds its value and rd_valid = 0.
//   Reads are legal in any state; reads while busy return stale or partial entries with rd_valid=0.
//  A read and a store to the same index in the same cycle return the old contents.
// STRUCTURE
//  aes_pkg (shared):
//   - RCON[1:10] table, NUM_RND, KEY_W=128
//   - sbox function / constant table
//   - ks_state_t enum {IDLE, WAIT, STORE, DONE}
//  Sub-module key_round_step, instantiated once.
//   - Ports: clk, rst, step_rnd[3:0], step_prev[127:0], step_key[127:0].
//   - Pipeline depth is exactly KSTEP_LAT: four S-boxes plus the XOR chain.
//  The top level holds the FSM, the counters, the 11x128 key store and the read mux/register.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
//    RK1 = a0fafe1788542cb123a339392a6c7605, RK10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//    done is seen exactly 31 cycles after the transfer.
//  2 All-zero key:
//    RK1 = 62636363626363636263636362636363, RK10 = b4ef5bcb3e92e21123e951cf6f8f188e.
//    rd_rnd = 11..15 -> rd_key = 0, rd_valid = 1.
//  3 Handshake:
//    key_valid held high during busy -> key_ready = 0, no second load.
//    Second key given in DONE -> sched_valid falls on the next edge and rises again with the new schedule after 31 cycles.
//  4 Reset mid-expansion (rnd_cnt = 5):
//    next cycle all outputs are at reset values, no done pulse, a read of RK3 returns 0.
//    A fresh key then expands correctly.
//  5 Read during busy returns rd_valid = 0.
//    Read the same index in the STORE cycle -> old value.
//    Read in DONE -> the new value with rd_valid = 1, exactly one cycle after rd_en.
//  6 Sweep KSTEP_LAT = 1, 3 with vector 1 -> same keys; done latency = 10*(KSTEP_LAT+1)+1 cycles.

Source files
------------

// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM states, Rcon and S-box helpers.
package aes_key_sched_ctrl_pkg;

    localparam int KEY_W   = 128;
    localparam int NUM_RND = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } ks_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_step.sv
// One AES-128 key-expansion round: previous round key -> next round key, KSTEP_LAT cycles deep.
module key_round_step
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int KSTEP_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   step_rnd,
    input  logic [127:0] step_prev,
    output logic [127:0] step_key
);

    logic [31:0]  temp_s;
    logic [31:0]  w0_s;
    logic [31:0]  w1_s;
    logic [31:0]  w2_s;
    logic [31:0]  w3_s;
    logic [127:0] pipe_r [KSTEP_LAT];

    // Round function: RotWord/SubWord/Rcon on w3, then the word XOR chain
    always_comb begin
        temp_s = sub_word({step_prev[23:0], step_prev[31:24]}) ^ {rcon(step_rnd), 24'h000000};
        w0_s   = step_prev[127:96] ^ temp_s;
        w1_s   = step_prev[95:64]  ^ w0_s;
        w2_s   = step_prev[63:32]  ^ w1_s;
        w3_s   = step_prev[31:0]   ^ w2_s;
    end

    // Delay line giving exactly KSTEP_LAT register stages to the output
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KSTEP_LAT; i++) begin
                pipe_r[i] <= 128'h0;
            end
        end else begin
            pipe_r[0] <= {w0_s, w1_s, w2_s, w3_s};
            for (int i = 1; i < KSTEP_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign step_key = pipe_r[KSTEP_LAT-1];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer: loads a cipher key, expands RK1..RK10 and serves round keys.
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int KSTEP_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         sched_valid,
    output logic         done,
    input  logic         rd_en,
    input  logic [3:0]   rd_rnd,
    output logic [127:0] rd_key,
    output logic         rd_valid
);

    localparam logic [1:0] WAIT_LAST = 2'(KSTEP_LAT - 1);
    localparam logic [3:0] LAST_RND  = 4'(NUM_RND);

    ks_state_t    state_r;
    ks_state_t    next_state_s;
    logic [3:0]   rnd_cnt_r;
    logic [1:0]   wait_cnt_r;
    logic [127:0] rk_r [0:10];
    logic         sched_valid_r;
    logic         done_r;
    logic         key_ready_r;
    logic         busy_r;
    logic [127:0] rd_key_r;
    logic         rd_valid_r;
    logic         xfer_s;
    logic [127:0] step_prev_s;
    logic [127:0] step_key_s;

    assign xfer_s = key_valid & key_ready_r;

    // Previous round key held stable on the step inputs for the whole round
    always_comb begin
        if (rnd_cnt_r == 4'd0) begin
            step_prev_s = 128'h0;
        end else begin
            step_prev_s = rk_r[rnd_cnt_r - 4'd1];
        end
    end

    key_round_step #(
        .KSTEP_LAT (KSTEP_LAT)
    ) u_step (
        .clk       (clk),
        .rst       (rst),
        .step_rnd  (rnd_cnt_r),
        .step_prev (step_prev_s),
        .step_key  (step_key_s)
    );

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (xfer_s) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = state_r;
                end
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = STORE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            STORE: begin
                if (rnd_cnt_r == LAST_RND) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, counters and status flags; handshake flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            rnd_cnt_r     <= 4'd0;
            wait_cnt_r    <= 2'd0;
            sched_valid_r <= 1'b0;
            done_r        <= 1'b0;
            key_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            done_r      <= 1'b0;
            key_ready_r <= (next_state_s == IDLE) || (next_state_s == DONE);
            busy_r      <= (next_state_s == WAIT) || (next_state_s == STORE);
            case (state_r)
                IDLE, DONE: begin
                    if (xfer_s) begin
                        rnd_cnt_r     <= 4'd1;
                        wait_cnt_r    <= 2'd0;
                        sched_valid_r <= 1'b0;
                    end
                end
                WAIT: wait_cnt_r <= wait_cnt_r + 2'd1;
                STORE: begin
                    if (rnd_cnt_r == LAST_RND) begin
                        sched_valid_r <= 1'b1;
                        done_r        <= 1'b1;
                    end else begin
                        rnd_cnt_r  <= rnd_cnt_r + 4'd1;
                        wait_cnt_r <= 2'd0;
                    end
                end
                default: begin
                    rnd_cnt_r  <= 4'd0;
                    wait_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    // Round-key store: RK0 on load, RK[rnd_cnt] at the end of each round
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_RND; i++) begin
                rk_r[i] <= 128'h0;
            end
        end else if (xfer_s) begin
            rk_r[0] <= key_in;
        end else if (state_r == STORE) begin
            rk_r[rnd_cnt_r] <= step_key_s;
        end
    end

    // Registered read port; same-cycle store to the read index returns the old entry
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key_r   <= 128'h0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_en & sched_valid_r;
            if (rd_en) begin
                rd_key_r <= (rd_rnd <= LAST_RND) ? rk_r[rd_rnd] : 128'h0;
            end
        end
    end

    assign key_ready   = key_ready_r;
    assign busy        = busy_r;
    assign sched_valid = sched_valid_r;
    assign done        = done_r;
    assign rd_key      = rd_key_r;
    assign rd_valid    = rd_valid_r;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 and all-zero key vectors.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K_FIPS    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK1_ZERO  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] RK10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] K_OTHER   = 128'hffffffffffffffffffffffffffffffff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = 128'h0;
    logic         key_valid = 1'b0;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_rnd = 4'd0;

    logic         key_ready, busy, sched_valid, done, rd_valid;
    logic [127:0] rd_key;
    logic         key_ready_1, busy_1, sched_valid_1, done_1, rd_valid_1;
    logic [127:0] rd_key_1;
    logic         key_ready_3, busy_3, sched_valid_3, done_3, rd_valid_3;
    logic [127:0] rd_key_3;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.KSTEP_LAT(2)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .busy(busy), .sched_valid(sched_valid), .done(done), .rd_en(rd_en), .rd_rnd(rd_rnd),
        .rd_key(rd_key), .rd_valid(rd_valid)
    );

    aes_key_sched_ctrl #(.KSTEP_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready_1),
        .busy(busy_1), .sched_valid(sched_valid_1), .done(done_1), .rd_en(rd_en), .rd_rnd(rd_rnd),
        .rd_key(rd_key_1), .rd_valid(rd_valid_1)
    );

    aes_key_sched_ctrl #(.KSTEP_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready_3),
        .busy(busy_3), .sched_valid(sched_valid_3), .done(done_3), .rd_en(rd_en), .rd_rnd(rd_rnd),
        .rd_key(rd_key_3), .rd_valid(rd_valid_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_rk(input logic [3:0] idx);
        rd_en  = 1'b1;
        rd_rnd = idx;
        tick();
        rd_en  = 1'b0;
    endtask

    // Load key k; key_valid stays high until cycle 'hold' with key_in switched to 'other' after the transfer.
    // In the first round's STORE cycle RK1 is read and must still show old_rk1 with rd_valid low.
    task automatic run_key(input logic [127:0] k, input int hold, input logic [127:0] other,
                           input logic [127:0] old_rk1, output int lat);
        lat       = 0;
        key_in    = k;
        key_valid = 1'b1;
        for (int cnt = 1; cnt <= 60 && lat == 0; cnt++) begin
            tick();
            if (cnt == 1) begin
                key_in = other;
                check_eq("sched_drop", sched_valid, 1'b0);
            end
            if (cnt >= hold) key_valid = 1'b0;
            if (cnt == 3) begin
                rd_en  = 1'b1;
                rd_rnd = 4'd1;
            end
            if (cnt == 4) begin
                rd_en = 1'b0;
                check_eq("store_read_old", rd_key, old_rk1);
                check_eq("busy_read_valid", rd_valid, 1'b0);
            end
            if (cnt == 5) begin
                check_eq("busy_mid", busy, 1'b1);
                check_eq("ready_mid", key_ready, 1'b0);
            end
            if (cnt == 30) check_eq("sched_before_done", sched_valid, 1'b0);
            if (done) lat = cnt;
        end
        key_valid = 1'b0;
        check_eq("sched_at_done", sched_valid, 1'b1);
        tick();
        check_eq("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int lat, lat1, lat2, lat3, ndone;

        tick();
        tick();
        check_eq("rst_ready", key_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sched", sched_valid, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_rdvalid", rd_valid, 1'b0);
        check_eq("rst_rdkey", rd_key, 128'h0);
        rst = 1'b0;
        tick();

        // FIPS key into all three latency variants at once
        lat1 = 0; lat2 = 0; lat3 = 0;
        key_in    = K_FIPS;
        key_valid = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            key_valid = 1'b0;
            if (c == 1) begin
                check_eq("load_busy", busy, 1'b1);
                check_eq("load_ready", key_ready, 1'b0);
            end
            if (done && lat2 == 0) lat2 = c;
            if (done_1 && lat1 == 0) lat1 = c;
            if (done_3 && lat3 == 0) lat3 = c;
        end
        check_eq("lat_k2", 128'(lat2), 128'd31);
        check_eq("lat_k1", 128'(lat1), 128'd21);
        check_eq("lat_k3", 128'(lat3), 128'd41);
        check_eq("sched_k2", sched_valid, 1'b1);
        read_rk(4'd1);
        check_eq("fips_rk1_k2", rd_key, RK1_FIPS);
        check_eq("fips_rk1_k1", rd_key_1, RK1_FIPS);
        check_eq("fips_rk1_k3", rd_key_3, RK1_FIPS);
        check_eq("fips_rk1_valid", rd_valid, 1'b1);
        read_rk(4'd10);
        check_eq("fips_rk10_k2", rd_key, RK10_FIPS);
        check_eq("fips_rk10_k1", rd_key_1, RK10_FIPS);
        check_eq("fips_rk10_k3", rd_key_3, RK10_FIPS);
        read_rk(4'd0);
        check_eq("fips_rk0", rd_key, K_FIPS);
        tick();
        check_eq("rd_hold_key", rd_key, K_FIPS);
        check_eq("rd_idle_valid", rd_valid, 1'b0);

        // All-zero key loaded in DONE; RK1 read in its STORE cycle sees the FIPS value
        run_key(128'h0, 1, 128'h0, RK1_FIPS, lat);
        check_eq("zero_lat", 128'(lat), 128'd31);
        read_rk(4'd1);
        check_eq("zero_rk1", rd_key, RK1_ZERO);
        check_eq("zero_rk1_valid", rd_valid, 1'b1);
        read_rk(4'd10);
        check_eq("zero_rk10", rd_key, RK10_ZERO);
        for (int i = 11; i <= 15; i++) begin
            read_rk(4'(i));
            check_eq("oor_key", rd_key, 128'h0);
            check_eq("oor_valid", rd_valid, 1'b1);
        end

        // key_valid held through the busy period with a different key: only the first is taken
        run_key(K_FIPS, 28, K_OTHER, RK1_ZERO, lat);
        check_eq("hs_lat", 128'(lat), 128'd31);
        read_rk(4'd1);
        check_eq("hs_rk1", rd_key, RK1_FIPS);
        read_rk(4'd10);
        check_eq("hs_rk10", rd_key, RK10_FIPS);

        // Reset during round 5
        key_in    = 128'h0;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        check_eq("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_ready", key_ready, 1'b1);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_sched", sched_valid, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        check_eq("mid_rst_rdvalid", rd_valid, 1'b0);
        check_eq("mid_rst_rdkey", rd_key, 128'h0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
        end
        check_eq("no_done_after_rst", 128'(ndone), 128'd0);
        read_rk(4'd3);
        check_eq("rst_rk3", rd_key, 128'h0);
        check_eq("rst_rk3_valid", rd_valid, 1'b0);

        run_key(K_FIPS, 1, K_FIPS, 128'h0, lat);
        check_eq("post_rst_lat", 128'(lat), 128'd31);
        read_rk(4'd10);
        check_eq("post_rst_rk10", rd_key, RK10_FIPS);
        check_eq("post_rst_valid", rd_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
